// File: rtl/mand_pixel_sink.sv
// Avalon-MM write-only pixel sink: FWFT FIFO with linear framebuffer addressing on a valid/ready output.
// Optional build macro MAND_SINK_COLOR_EN maps iteration counts to RGB444 at push time.
module mand_pixel_sink #(
  parameter int WIDTH    = 32,
  parameter int PIX_W    = 12,
  parameter int DEPTH    = 16,
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int ADDR_W   = 19,
  parameter int MAX_ITER = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     avs_s0_write,
  input  logic [WIDTH-1:0]         avs_s0_writedata,
  output logic                     avs_s0_waitrequest,
  output logic                     fb_valid,
  input  logic                     fb_ready,
  output logic [ADDR_W-1:0]        fb_addr,
  output logic [PIX_W-1:0]         fb_data,
  output logic                     frame_done,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [FILL_W-1:0] FULL_FILL = FILL_W'(DEPTH);
  localparam logic [7:0]        MAX8 = 8'(MAX_ITER);

  // Handshakes: a write is accepted on a rising edge where avs_s0_write & !avs_s0_waitrequest;
  // a pixel leaves on a rising edge where fb_valid & fb_ready. clear overrides both.
  logic [PIX_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FILL_W-1:0] fill_q, fill_next;
  logic              full_reg;
  logic [ADDR_W-1:0] pix_idx;
  logic              frame_done_q;
  logic              push, pop, idx_last;
  logic [PIX_W-1:0]  pix_in;
  logic              unused_bits;

  assign avs_s0_waitrequest = full_reg | clear;
  assign push     = avs_s0_write & ~avs_s0_waitrequest;
  assign fb_valid = (fill_q != '0);
  assign pop      = fb_valid & fb_ready & ~clear;
  assign idx_last = (pix_idx == LAST_IDX);
  assign unused_bits = ^avs_s0_writedata;

`ifdef MAND_SINK_COLOR_EN
  // Palette: points inside the set are black, others spread nibbles across R/G/B.
  always_comb begin
    pix_in = '0;
    if (avs_s0_writedata[7:0] != MAX8)
      pix_in = {avs_s0_writedata[3:0], avs_s0_writedata[7:4], ~avs_s0_writedata[3:0]};
  end
`else
  logic unused_iter;
  assign unused_iter = (avs_s0_writedata[7:0] == MAX8);
  assign pix_in      = avs_s0_writedata[PIX_W-1:0];
`endif

  always_comb begin
    fill_next = fill_q;
    case ({push, pop})
      2'b10:   fill_next = fill_q + FILL_W'(1);
      2'b01:   fill_next = fill_q - FILL_W'(1);
      default: fill_next = fill_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill_q       <= '0;
      full_reg     <= 1'b0;
      pix_idx      <= '0;
      frame_done_q <= 1'b0;
    end else if (clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill_q       <= '0;
      full_reg     <= 1'b0;
      pix_idx      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        pix_idx <= idx_last ? '0 : pix_idx + ADDR_W'(1);
      end
      fill_q       <= fill_next;
      // Registered full keeps waitrequest free of any path from avs_s0_write.
      full_reg     <= (fill_next == FULL_FILL);
      frame_done_q <= pop & idx_last;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pix_in;
  end

  assign fb_data    = mem[rd_ptr];
  assign fb_addr    = pix_idx;
  assign frame_done = frame_done_q;
  assign fill       = fill_q;

endmodule

// File: tb/tb_mand_pixel_sink.sv
// Directed bench for mand_pixel_sink: vector table plus hand sequences for reset, clear, palette and a full frame.
module tb_mand_pixel_sink;

  localparam int H = 4;
  localparam int V = 3;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] wd = '0;
  logic        wait_o;
  logic        fb_valid;
  logic        rdy = 1'b0;
  logic [3:0]  fb_addr;
  logic [11:0] fb_data;
  logic        fb_done;
  logic [2:0]  fill;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];

  mand_pixel_sink #(
    .WIDTH(32), .PIX_W(12), .DEPTH(D), .H_RES(H), .V_RES(V), .ADDR_W(4), .MAX_ITER(255)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .avs_s0_write(wr), .avs_s0_writedata(wd), .avs_s0_waitrequest(wait_o),
    .fb_valid(fb_valid), .fb_ready(rdy), .fb_addr(fb_addr), .fb_data(fb_data),
    .frame_done(fb_done), .fill(fill)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (fb_done === 1'b1) done_cnt++;

  function automatic logic [11:0] exp_pix(input logic [31:0] w);
`ifdef MAND_SINK_COLOR_EN
    if (w[7:0] == 8'hFF) return 12'h000;
    return {w[3:0], w[7:4], ~w[3:0]};
`else
    return w[11:0];
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Driver: called at a negedge, returns at a later negedge with write dropped.
  task automatic push(input logic [31:0] w);
    int t;
    wr = 1'b1; wd = w; #1;
    t = 0;
    while (wait_o && t < 20) begin @(negedge clk); #1; t++; end
    if (t == 20) check("push_timeout", 32'(wait_o), 32'h0);
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic pop_one();
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] wd;
    logic        rdy;
    logic        e_wait;
    logic        e_valid;
    logic [31:0] e_word;
    logic [3:0]  e_addr;
    logic [2:0]  e_fill;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic w, input logic [31:0] d, input logic r, input logic ew,
                              input logic ev, input logic [31:0] ewd, input logic [3:0] ea,
                              input logic [2:0] ef);
    vec_t v;
    v.wr = w; v.wd = d; v.rdy = r; v.e_wait = ew; v.e_valid = ev;
    v.e_word = ewd; v.e_addr = ea; v.e_fill = ef;
    return v;
  endfunction

  initial begin
    int sent, popped, done_seen;
    logic [3:0] exp_addr;
    logic prev_last;
    logic [31:0] head;

    // Each row: inputs for one cycle, outputs expected during that cycle (before its edge).
    tbl[0]  = mk(1, 32'h5,         0, 0, 0, 32'h0,         0, 0);
    tbl[1]  = mk(1, 32'h6,         0, 0, 1, 32'h5,         0, 1);
    tbl[2]  = mk(1, 32'h7,         0, 0, 1, 32'h5,         0, 2);
    tbl[3]  = mk(1, 32'h8,         0, 0, 1, 32'h5,         0, 3);
    tbl[4]  = mk(1, 32'h9,         0, 1, 1, 32'h5,         0, 4);
    tbl[5]  = mk(1, 32'h9,         1, 1, 1, 32'h5,         0, 4);
    tbl[6]  = mk(1, 32'h9,         0, 0, 1, 32'h6,         1, 3);
    tbl[7]  = mk(0, 32'h0,         1, 1, 1, 32'h6,         1, 4);
    tbl[8]  = mk(0, 32'h0,         1, 0, 1, 32'h7,         2, 3);
    tbl[9]  = mk(0, 32'h0,         1, 0, 1, 32'h8,         3, 2);
    tbl[10] = mk(0, 32'h0,         1, 0, 1, 32'h9,         4, 1);
    tbl[11] = mk(1, 32'h1234_5ABC, 1, 0, 0, 32'h0,         5, 0);
    tbl[12] = mk(1, 32'h0000_0777, 1, 0, 1, 32'h1234_5ABC, 5, 1);
    tbl[13] = mk(0, 32'h0,         0, 0, 1, 32'h0000_0777, 6, 1);
    tbl[14] = mk(0, 32'h0,         1, 0, 1, 32'h0000_0777, 6, 1);
    tbl[15] = mk(0, 32'h0,         0, 0, 0, 32'h0,         7, 0);

    // Reset held with a write presented.
    wr = 1'b1; wd = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    #1;
    check("rst_wait", 32'(wait_o), 0);
    check("rst_valid", 32'(fb_valid), 0);
    check("rst_fill", 32'(fill), 0);
    check("rst_addr", 32'(fb_addr), 0);
    check("rst_done", 32'(fb_done), 0);
    @(negedge clk);
    wr = 1'b0; rst = 1'b1;
    @(negedge clk); #1;
    check("post_rst_fill", 32'(fill), 0);
    check("post_rst_valid", 32'(fb_valid), 0);
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      wr = tbl[i].wr; wd = tbl[i].wd; rdy = tbl[i].rdy;
      #1;
      check($sformatf("v%0d_wait", i), 32'(wait_o), 32'(tbl[i].e_wait));
      check($sformatf("v%0d_valid", i), 32'(fb_valid), 32'(tbl[i].e_valid));
      check($sformatf("v%0d_fill", i), 32'(fill), 32'(tbl[i].e_fill));
      check($sformatf("v%0d_addr", i), 32'(fb_addr), 32'(tbl[i].e_addr));
      check($sformatf("v%0d_done", i), 32'(fb_done), 0);
      if (tbl[i].e_valid)
        check($sformatf("v%0d_data", i), 32'(fb_data), 32'(exp_pix(tbl[i].e_word)));
      @(negedge clk);
    end
    wr = 1'b0; rdy = 1'b0;

    // Asynchronous reset mid-operation.
    push(32'h11); push(32'h12);
    #2; rst = 1'b0; #1;
    check("async_rst_fill", 32'(fill), 0);
    check("async_rst_valid", 32'(fb_valid), 0);
    check("async_rst_addr", 32'(fb_addr), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Clear with three pixels queued at index 2.
    push(32'h21); push(32'h22); push(32'h23);
    pop_one(); pop_one();
    push(32'h24); push(32'h25);
    #1;
    check("pre_clr_fill", 32'(fill), 3);
    check("pre_clr_addr", 32'(fb_addr), 2);
    @(negedge clk);
    clear = 1'b1; wr = 1'b1; wd = 32'hAAA; #1;
    check("clr_wait", 32'(wait_o), 1);
    @(negedge clk);
    clear = 1'b0; wr = 1'b0; #1;
    check("clr_fill", 32'(fill), 0);
    check("clr_valid", 32'(fb_valid), 0);
    check("clr_wait_after", 32'(wait_o), 0);
    @(negedge clk);
    push(32'h0000_0B0B);
    #1;
    check("clr_next_addr", 32'(fb_addr), 0);
    check("clr_next_data", 32'(fb_data), 32'(exp_pix(32'h0000_0B0B)));
    check("clr_no_done", 32'(done_cnt), 0);
    @(negedge clk);

    // Palette / width handling.
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    push(32'hABCD_E0FF); push(32'h0000_002A);
    #1;
`ifdef MAND_SINK_COLOR_EN
    check("pal_inside", 32'(fb_data), 32'h000);
`else
    check("raw_low_bits", 32'(fb_data), 32'h0FF);
`endif
    @(negedge clk);
    pop_one(); #1;
`ifdef MAND_SINK_COLOR_EN
    check("pal_2a", 32'(fb_data), 32'hA25);
`else
    check("raw_2a", 32'(fb_data), 32'h02A);
`endif
    @(negedge clk);

    // Full frame of 12 pixels plus one more, consumer always ready.
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    sent = 0; popped = 0; done_seen = 0; exp_addr = '0; prev_last = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 30; cyc++) begin
      wr = (sent < 13); wd = 32'h100 + 32'(sent); rdy = 1'b1;
      #1;
      check("frame_done", 32'(fb_done), 32'(prev_last));
      if (fb_done) done_seen++;
      prev_last = 1'b0;
      if (fb_valid) begin
        if (exp_q.size() == 0) begin
          check("frame_unexpected_pop", 32'(fb_valid), 0);
        end else begin
          head = exp_q.pop_front();
          check("frame_data", 32'(fb_data), 32'(exp_pix(head)));
          check("frame_addr", 32'(fb_addr), 32'(exp_addr));
          prev_last = (exp_addr == 4'(H * V - 1));
          exp_addr  = prev_last ? 4'd0 : exp_addr + 4'd1;
          popped++;
        end
      end
      if (wr && !wait_o) begin
        exp_q.push_back(wd);
        sent++;
      end
      @(negedge clk);
    end
    wr = 1'b0; rdy = 1'b0;
    check("frame_pops", 32'(popped), 13);
    check("frame_done_count", 32'(done_seen), 1);
    check("frame_wrap_addr", 32'(exp_addr), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
